// File: rtl/vga_bus_arbiter.sv
// rtl/vga_bus_arbiter.sv - single-port RAM arbiter: VGA fetcher has absolute priority,
// CPU gets a req/ack handshake and a one-entry posted write buffer.
module vga_bus_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_dat,
  input  logic              i_cpu_cs,
  input  logic              i_cpu_we,
  output logic [DATA_W-1:0] o_cpu_dat,
  output logic              o_cpu_ack,
  input  logic [ADDR_W-1:0] i_vga_addr,
  input  logic              i_vga_cs,
  input  logic              i_vga_access,
  output logic [DATA_W-1:0] o_vga_dat,
  output logic              o_vga_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_dat,
  output logic              o_mem_cs,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_dat
);

  typedef enum logic [1:0] {IDLE, RD_DATA, ACK} state_t;

  state_t            state, state_nxt;
  logic              r_vga_slot;
  logic              wbuf_valid;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [DATA_W-1:0] wbuf_dat;
  logic [DATA_W-1:0] r_cpu_dat;
  logic              r_vga_err;

  logic vga_grant;
  logic drain;
  logic rd_issue;
  logic wr_load;

  // An unannounced VGA cs still wins the bus; it is only flagged as an error.
  always_comb begin
    vga_grant = r_vga_slot | i_vga_cs;
    drain     = !vga_grant && wbuf_valid;
    rd_issue  = !vga_grant && !wbuf_valid && (state == IDLE) && i_cpu_cs && !i_cpu_we;
    wr_load   = (state == IDLE) && i_cpu_cs && i_cpu_we && !wbuf_valid;
  end

  always_comb begin
    o_mem_addr = '0;
    o_mem_dat  = '0;
    o_mem_cs   = 1'b0;
    o_mem_we   = 1'b0;
    if (vga_grant) begin
      o_mem_addr = i_vga_addr;
      o_mem_cs   = i_vga_cs;
    end else if (drain) begin
      o_mem_addr = wbuf_addr;
      o_mem_dat  = wbuf_dat;
      o_mem_cs   = 1'b1;
      o_mem_we   = 1'b1;
    end else if (rd_issue) begin
      o_mem_addr = i_cpu_addr;
      o_mem_cs   = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_load) begin
          state_nxt = ACK;
        end else if (rd_issue) begin
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      r_vga_slot <= 1'b0;
      wbuf_valid <= 1'b0;
      wbuf_addr  <= '0;
      wbuf_dat   <= '0;
      r_cpu_dat  <= '0;
      r_vga_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      r_vga_slot <= i_vga_access;
      if (wr_load) begin
        wbuf_valid <= 1'b1;
        wbuf_addr  <= i_cpu_addr;
        wbuf_dat   <= i_cpu_dat;
      end else if (drain) begin
        wbuf_valid <= 1'b0;
      end
      if (state == RD_DATA) begin
        r_cpu_dat <= i_mem_dat;
      end
      if (i_vga_cs && !r_vga_slot) begin
        r_vga_err <= 1'b1;
      end
    end
  end

  assign o_cpu_ack = (state == ACK);
  assign o_cpu_dat = r_cpu_dat;
  assign o_vga_dat = i_mem_dat;
  assign o_vga_err = r_vga_err;

endmodule

// File: tb/tb_vga_bus_arbiter.sv
// tb/tb_vga_bus_arbiter.sv - table-driven bench for vga_bus_arbiter with a small
// synchronous RAM model behind the memory port.
module tb_vga_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        cpu_cs;
  logic        cpu_we;
  logic [7:0]  cpu_rdat;
  logic        cpu_ack;
  logic [15:0] vga_addr;
  logic        vga_cs;
  logic        vga_access;
  logic [7:0]  vga_dat;
  logic        vga_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdat;
  logic        mem_cs;
  logic        mem_we;
  logic [7:0]  mem_rdat;

  logic [7:0]  ram [0:65535];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_bus_arbiter dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_dat    (cpu_dat),
    .i_cpu_cs     (cpu_cs),
    .i_cpu_we     (cpu_we),
    .o_cpu_dat    (cpu_rdat),
    .o_cpu_ack    (cpu_ack),
    .i_vga_addr   (vga_addr),
    .i_vga_cs     (vga_cs),
    .i_vga_access (vga_access),
    .o_vga_dat    (vga_dat),
    .o_vga_err    (vga_err),
    .o_mem_addr   (mem_addr),
    .o_mem_dat    (mem_wdat),
    .o_mem_cs     (mem_cs),
    .o_mem_we     (mem_we),
    .i_mem_dat    (mem_rdat)
  );

  // Read-first synchronous RAM; preloaded while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      ram[16'h2345] <= 8'hA5;
      ram[16'h0042] <= 8'h3C;
      ram[16'h1000] <= 8'h11;
      mem_rdat      <= 8'h00;
    end else if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_wdat;
      mem_rdat <= ram[mem_addr];
    end
  end

  typedef struct {
    logic        cs;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  dat;
    logic        acc;
    logic        vcs;
    logic [15:0] vaddr;
    logic        e_cs;
    logic        e_we;
    logic [15:0] e_addr;
    logic [7:0]  e_wdat;
    logic        e_ack;
    logic [7:0]  e_rdat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic cs, input logic we, input logic [15:0] addr,
                              input logic [7:0] dat, input logic acc, input logic vcs,
                              input logic [15:0] vaddr, input logic e_cs, input logic e_we,
                              input logic [15:0] e_addr, input logic [7:0] e_wdat,
                              input logic e_ack, input logic [7:0] e_rdat);
    vec_t v;
    v.cs = cs; v.we = we; v.addr = addr; v.dat = dat;
    v.acc = acc; v.vcs = vcs; v.vaddr = vaddr;
    v.e_cs = e_cs; v.e_we = e_we; v.e_addr = e_addr; v.e_wdat = e_wdat;
    v.e_ack = e_ack; v.e_rdat = e_rdat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cs, input logic we, input logic [15:0] addr,
                       input logic [7:0] dat, input logic acc, input logic vcs,
                       input logic [15:0] vaddr);
    cpu_cs = cs; cpu_we = we; cpu_addr = addr; cpu_dat = dat;
    vga_access = acc; vga_cs = vcs; vga_addr = vaddr;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 16'h0, 8'h0, 0, 0, 16'h0);

    // T2 read on free bus
    vecs.push_back(mk(1,0,16'h2345,8'h00, 0,0,16'h0000, 1,0,16'h2345,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,16'h2345,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,16'h2345,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 1,8'hA5));
    vecs.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    // T3 read delayed by two VGA slots, second one used at 0x1000
    vecs.push_back(mk(0,0,16'h0000,8'h00, 1,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,16'h0042,8'h00, 1,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,16'h0042,8'h00, 0,1,16'h1000, 1,0,16'h1000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,16'h0042,8'h00, 0,0,16'h0000, 1,0,16'h0042,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,16'h0042,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,16'h0042,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 1,8'h3C));
    vecs.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    // T4 posted write then read-back
    vecs.push_back(mk(1,1,16'h1000,8'h5A, 0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,1,16'h1000,8'h5A, 0,0,16'h0000, 1,1,16'h1000,8'h5A, 1,8'h00));
    vecs.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,16'h1000,8'h00, 0,0,16'h0000, 1,0,16'h1000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,16'h1000,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,16'h1000,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 1,8'h5A));
    vecs.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    // T5 drain blocked by VGA slots at t+1,t+2; second write stalls until drained
    vecs.push_back(mk(1,1,16'h0100,8'h77, 1,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,1,16'h0100,8'h77, 1,0,16'h0000, 0,0,16'h0000,8'h00, 1,8'h00));
    vecs.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,1,16'h0101,8'h88, 0,0,16'h0000, 1,1,16'h0100,8'h77, 0,8'h00));
    vecs.push_back(mk(1,1,16'h0101,8'h88, 0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,1,16'h0101,8'h88, 0,0,16'h0000, 1,1,16'h0101,8'h88, 1,8'h00));
    vecs.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,16'h0100,8'h00, 0,0,16'h0000, 1,0,16'h0100,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,16'h0100,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));
    vecs.push_back(mk(1,0,16'h0100,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 1,8'h77));
    vecs.push_back(mk(0,0,16'h0000,8'h00, 0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00));

    // T1 reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst mem_cs", mem_cs, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_dat", mem_wdat, 0);
    chk("rst cpu_ack", cpu_ack, 0);
    chk("rst cpu_dat", cpu_rdat, 0);
    chk("rst vga_dat", vga_dat, 0);
    chk("rst vga_err", vga_err, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].dat,
            vecs[i].acc, vecs[i].vcs, vecs[i].vaddr);
      #1;
      chk($sformatf("v%0d mem_cs", i), mem_cs, vecs[i].e_cs);
      chk($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_we);
      if (vecs[i].e_cs) chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      if (vecs[i].e_we) chk($sformatf("v%0d mem_dat", i), mem_wdat, vecs[i].e_wdat);
      chk($sformatf("v%0d cpu_ack", i), cpu_ack, vecs[i].e_ack);
      if (vecs[i].e_ack && !vecs[i].we)
        chk($sformatf("v%0d cpu_dat", i), cpu_rdat, vecs[i].e_rdat);
      chk($sformatf("v%0d vga_err", i), vga_err, 0);
    end

    // T6 unannounced VGA cs: granted, CPU read held off, error sticks until reset
    @(negedge clk);
    drive(1, 0, 16'h2345, 8'h00, 0, 1, 16'h0200);
    #1;
    chk("t6 vga mem_cs", mem_cs, 1);
    chk("t6 vga mem_addr", mem_addr, 16'h0200);
    chk("t6 vga mem_we", mem_we, 0);
    chk("t6 err not yet", vga_err, 0);
    @(negedge clk);
    drive(1, 0, 16'h2345, 8'h00, 0, 0, 16'h0000);
    #1;
    chk("t6 err set", vga_err, 1);
    chk("t6 rd mem_cs", mem_cs, 1);
    chk("t6 rd mem_addr", mem_addr, 16'h2345);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t6 rd ack", cpu_ack, 1);
    chk("t6 rd dat", cpu_rdat, 8'hA5);
    @(negedge clk);
    drive(0, 0, 16'h0, 8'h0, 0, 0, 16'h0);
    #1;
    chk("t6 err sticky", vga_err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6 err cleared", vga_err, 0);
    chk("t6 ack cleared", cpu_ack, 0);

    // Reset during a buffered write: no drain afterwards
    @(negedge clk);
    drive(1, 1, 16'h0300, 8'h99, 1, 0, 16'h0000);
    #1;
    chk("rw load mem_cs", mem_cs, 0);
    @(negedge clk);
    drive(1, 1, 16'h0300, 8'h99, 0, 0, 16'h0000);
    rst = 1'b1;
    #1;
    chk("rw ack shown", cpu_ack, 1);
    chk("rw slot mem_cs", mem_cs, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 16'h0, 8'h0, 0, 0, 16'h0);
    #1;
    chk("rw no drain", mem_cs, 0);
    chk("rw no ack", cpu_ack, 0);
    @(negedge clk);
    #1;
    chk("rw still idle", mem_cs, 0);

    // Reset during a read: no ack
    @(negedge clk);
    drive(1, 0, 16'h2345, 8'h00, 0, 0, 16'h0000);
    #1;
    chk("rr issue", mem_cs, 1);
    @(negedge clk);
    drive(0, 0, 16'h0, 8'h0, 0, 0, 16'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rr no ack 1", cpu_ack, 0);
    @(negedge clk);
    #1;
    chk("rr no ack 2", cpu_ack, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
